math_sched: RTL
===============

# math_sched

Request scheduler and reconfiguration controller in front of the reconfigurable math engine (the 32-bit two-operand `ain`/`bin` → `result`/`statistic` region) of `xps_math`. It round-robin-shares the single engine between two requesters and tags responses with the requester id. It also sequences partial reconfiguration: it quiesces and drains the engine, snapshots its `statistic` register for state migration, isolates the engine during the swap, and then restarts it cleanly.

## Interface
- `ENG_LAT`, default 1: engine latency, in cycles, from a stable operand to updated `result` (≥1).
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `r0_valid` in 1, `r0_ready` out 1, `r0_ain` in 32, `r0_bin` in 32: requester 0 operand handshake.
- `r1_valid` in 1, `r1_ready` out 1, `r1_ain` in 32, `r1_bin` in 32: requester 1 operand handshake.
- `rsp_valid` out 1: response strobe. There is no backpressure; the consumer must take it.
- `rsp_id` out 1: requester that issued the response.
- `rsp_data` out 32: engine result for that request.
- `eng_ain` out 32, `eng_bin` out 32: registered operands to the engine.
- `eng_result` in 32, `eng_statistic` in 32: engine outputs.
- `eng_rst` out 1: engine reset.
- `pr_req` in 1: request to quiesce for reconfiguration (level).
- `pr_ack` out 1: engine is drained and isolated; safe to reconfigure.
- `stat_snap` out 32: `eng_statistic` captured at drain completion.

## Operation
- FSM states are RUN, DRAIN, HOLD and RESTART. `rst` forces RESTART.
- RESTART
  - Lasts one cycle, with `eng_rst`=1.
  - `eng_ain`/`eng_bin` are set to 0, so the post-reset result stays 0 and the statistic does not spuriously count.
  - Always moves to RUN.
- RUN
  - A `rN_ready` is granted only when the state is RUN and `pr_req`=0. At most one grant per cycle.
  - The ready signals are combinational from valid, pointer, state and `pr_req`.
  - Arbitration is round-robin. With one requester valid, that requester is granted. With both valid, the requester other than `last` is granted.
  - `last` updates only on a transfer (valid&ready). Reset value of `last` is 1, so r0 wins the first tie.
  - On a transfer, the operands are registered into `eng_ain`/`eng_bin`, and the id enters a tag shift pipe of depth `ENG_LAT`+1.
  - With no transfer, `eng_ain`/`eng_bin` hold their values, so the engine result and statistic stay unchanged.
  - If `pr_req`=1, the FSM moves to DRAIN.
- DRAIN
  - No grants.
  - When the tag pipe is empty, including any response issuing this cycle, the controller captures `stat_snap`←`eng_statistic` and moves to HOLD.
- HOLD
  - `pr_ack`=1 and `eng_rst`=1.
  - No grants, and operands are held.
  - Moves to RESTART when `pr_req`=0.
  - If `pr_req` drops during DRAIN, the drain still completes and HOLD lasts exactly one cycle.
- `eng_rst` = 1 in RESTART and HOLD, and 0 otherwise.
- Responses: `rsp_valid` is the tag pipe output valid and `rsp_id` is its id. `rsp_data` = `eng_result` (combinational pass-through), valid only while `rsp_valid`=1.
- Reset values:
  - `r0_ready`=`r1_ready`=0, `rsp_valid`=0, `rsp_id`=0.
  - `eng_ain`=`eng_bin`=0, `eng_rst`=1.
  - `pr_ack`=0, `stat_snap`=0, tag pipe empty.
- Reset mid-operation: in-flight tags are discarded and no response is emitted for them. `stat_snap` is cleared.

## Timing
- Transfer in cycle c → operands on `eng_*` in cycle c+1 → `rsp_valid` in cycle c+1+`ENG_LAT` (c+2 at default).
- Throughput is one request per cycle, with back-to-back responses in issue order.
- `pr_req` rising in cycle p: no grant in cycle p.
  - DRAIN begins at cycle p+1.
  - HOLD (`pr_ack`=1) starts one cycle after the last in-flight response.
  - With nothing in flight, HOLD starts at p+2.
- `pr_req` falling in HOLD cycle h: RESTART in h+1, RUN in h+2, first grant possible in h+2.
- After `rst` deasserts: RESTART for one cycle, then RUN. The first grant is possible in the second cycle after deassertion.

## Test plan
- **Single request.** r0 sends ain=5, bin=9 in cycle c → `rsp_valid`=1, `rsp_id`=0, `rsp_data`=9 in cycle c+2. No other grant occurs.
- **Fairness.** Both requesters hold valid for 6 cycles (r0: 1/2, r1: 7/3) → grants alternate r0,r1,r0,… Responses alternate id 0/1 with data 2/7.
- **Idle hold.** After one transfer (3,4), both valids are idle for 10 cycles → `eng_ain`/`eng_bin` stay 3/4 and `eng_statistic`[15:0] stays constant.
- **Drain with traffic in flight.** Transfers occur in cycles c and c+1, and `pr_req` rises in c+1 (the second transfer is blocked). Required response:
  - exactly one response, at c+2;
  - `pr_ack` at c+3;
  - `stat_snap` = `eng_statistic` sampled at c+2;
  - `eng_rst`=1 while `pr_ack` is high.
- **Restart.** `pr_req` drops in HOLD → one RESTART cycle with `eng_ain`=`eng_bin`=0 and `eng_rst`=1, then grants resume. The engine statistic stays at reset value f00d0000 until the first result differing from 0.
- **Reset mid-flight.** `rst` is asserted the cycle after a transfer → no `rsp_valid`, all outputs at reset values, and RUN is reached 2 cycles after `rst` deasserts.

Source files
------------

// File: rtl/math_sched.sv
// math_sched: round-robin front end for the shared math engine, plus the
// quiesce / drain / isolate / restart sequence used around partial
// reconfiguration of the engine region.
module math_sched #(
    parameter int ENG_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [31:0] r0_ain,
    input  logic [31:0] r0_bin,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [31:0] r1_ain,
    input  logic [31:0] r1_bin,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic [31:0] eng_ain,
    output logic [31:0] eng_bin,
    input  logic [31:0] eng_result,
    input  logic [31:0] eng_statistic,
    output logic        eng_rst,
    input  logic        pr_req,
    output logic        pr_ack,
    output logic [31:0] stat_snap
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_DRAIN   = 2'd1,
        S_HOLD    = 2'd2,
        S_RESTART = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic [31:0]         ain_q, ain_d;
    logic [31:0]         bin_q, bin_d;
    logic [31:0]         snap_q, snap_d;
    // Tag pipe: stage 0 is loaded on a transfer, stage ENG_LAT lines up with
    // the engine result for that transfer.
    logic [ENG_LAT:0]    tag_vld_q, tag_vld_d;
    logic [ENG_LAT:0]    tag_id_q, tag_id_d;

    logic                grant_ok;
    logic                gnt0, gnt1;
    logic                xfer;
    logic                in_flight;

    // Arbitration: only in RUN with no pending quiesce; tie goes to the
    // requester that did not win last.
    always_comb begin
        grant_ok = (state_q == S_RUN) && !pr_req;
        gnt0     = grant_ok && r0_valid && (!r1_valid || last_q);
        gnt1     = grant_ok && r1_valid && (!r0_valid || !last_q);
        xfer     = gnt0 || gnt1;
        // The last stage may be issuing its response this cycle; only the
        // earlier stages count as still outstanding.
        in_flight = |tag_vld_q[ENG_LAT-1:0];
    end

    // Next-state, operand, pointer, tag pipe and snapshot logic.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        ain_d     = ain_q;
        bin_d     = bin_q;
        snap_d    = snap_q;
        tag_vld_d = {tag_vld_q[ENG_LAT-1:0], xfer};
        tag_id_d  = {tag_id_q[ENG_LAT-1:0], gnt1};

        if (gnt0) begin
            ain_d  = r0_ain;
            bin_d  = r0_bin;
            last_d = 1'b0;
        end else if (gnt1) begin
            ain_d  = r1_ain;
            bin_d  = r1_bin;
            last_d = 1'b1;
        end

        unique case (state_q)
            S_RUN: begin
                if (pr_req) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!in_flight) begin
                    snap_d  = eng_statistic;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // Zero the operands as we leave isolation so the engine
                // comes out of reset computing on a quiet input.
                if (!pr_req) begin
                    ain_d   = '0;
                    bin_d   = '0;
                    state_d = S_RESTART;
                end
            end
            S_RESTART: begin
                ain_d   = '0;
                bin_d   = '0;
                state_d = S_RUN;
            end
            default: state_d = S_RESTART;
        endcase
    end

    // State registers; reset discards in-flight tags and the snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RESTART;
            last_q    <= 1'b1;
            ain_q     <= '0;
            bin_q     <= '0;
            snap_q    <= '0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            ain_q     <= ain_d;
            bin_q     <= bin_d;
            snap_q    <= snap_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    assign r0_ready  = gnt0;
    assign r1_ready  = gnt1;
    assign rsp_valid = tag_vld_q[ENG_LAT];
    assign rsp_id    = tag_id_q[ENG_LAT];
    assign rsp_data  = eng_result;
    assign eng_ain   = ain_q;
    assign eng_bin   = bin_q;
    assign eng_rst   = (state_q == S_HOLD) || (state_q == S_RESTART);
    assign pr_ack    = (state_q == S_HOLD);
    assign stat_snap = snap_q;

endmodule
